// File: rtl/uart_byte_tx.sv
// Purpose : 8N1 UART transmitter (optional even parity) with a one-entry pending buffer
//           that absorbs a request arriving while a frame is in flight.
// Latency : tx falls one edge after the trigger. The ready pulse is in the last stop cycle,
//           10*CLKS_PER_BIT cycles after the trigger (11*CLKS_PER_BIT with parity).
// Backpr. : none on the input. A request that arrives while a frame is in flight and the
//           pending entry is full is dropped, and sticky overrun is set.
//
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit between data bit 7 and stop).
//
// Ports:
//   clk                     in   system clock, rising edge
//   reset                   in   synchronous active-high reset
//   io_output_value[7:0]    in   byte to send, sampled when io_output_trigger=1
//   io_output_trigger       in   one-cycle request strobe
//   io_output_ready_trigger out  one-cycle pulse in the final stop cycle of each frame
//   tx                      out  serial line, idles high
//   busy                    out  frame in flight or byte pending
//   overrun                 out  sticky, set when a request is dropped
module uart_byte_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] io_output_value,
  input  logic       io_output_trigger,
  output logic       io_output_ready_trigger,
  output logic       tx,
  output logic       busy,
  output logic       overrun
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  // The ready flag is registered, so it is raised one cycle before the last stop cycle.
  localparam logic [15:0] BAUD_PRE  = 16'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] baud_cnt, baud_nxt;
  logic [2:0]  bit_cnt, bit_nxt;
  logic [7:0]  shift_q, shift_nxt;
  logic        pend_vld, pend_vld_nxt;
  logic [7:0]  pend_dat, pend_dat_nxt;
  logic        tx_nxt;
  logic        rdy_nxt;
  logic        ovr_nxt;
  logic        busy_nxt;
  logic        baud_last;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_nxt;
`endif

  assign baud_last = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_nxt    = state;
    baud_nxt     = 16'd0;
    bit_nxt      = bit_cnt;
    shift_nxt    = shift_q;
    pend_vld_nxt = pend_vld;
    pend_dat_nxt = pend_dat;
    tx_nxt       = tx;
    rdy_nxt      = 1'b0;
    ovr_nxt      = overrun;
`ifdef UART_TX_PARITY_EN
    par_nxt      = par_q;
`endif

    // The baud counter restarts from 0 on every state change and stays at 0 in IDLE.
    if (state != S_IDLE && !baud_last) begin
      baud_nxt = baud_cnt + 16'd1;
    end

    // A request outside IDLE goes to the pending entry, or is dropped if that entry is full.
    // A request in the final stop cycle lands here too, and the STOP branch below picks it
    // up in the same cycle.
    if (io_output_trigger && state != S_IDLE) begin
      if (!pend_vld) begin
        pend_vld_nxt = 1'b1;
        pend_dat_nxt = io_output_value;
      end else begin
        ovr_nxt = 1'b1;
      end
    end

    case (state)
      S_IDLE: begin
        if (io_output_trigger) begin
          state_nxt = S_START;
          tx_nxt    = 1'b0;
          shift_nxt = io_output_value;
          bit_nxt   = 3'd0;
`ifdef UART_TX_PARITY_EN
          par_nxt   = ^io_output_value;
`endif
        end
      end

      S_START: begin
        if (baud_last) begin
          state_nxt = S_DATA;
          tx_nxt    = shift_q[0];
          shift_nxt = {1'b0, shift_q[7:1]};
          bit_nxt   = 3'd0;
        end
      end

      S_DATA: begin
        if (baud_last) begin
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = S_PARITY;
            tx_nxt    = par_q;
`else
            state_nxt = S_STOP;
            tx_nxt    = 1'b1;
`endif
          end else begin
            bit_nxt   = bit_cnt + 3'd1;
            tx_nxt    = shift_q[0];
            shift_nxt = {1'b0, shift_q[7:1]};
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          state_nxt = S_STOP;
          tx_nxt    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (baud_cnt == BAUD_PRE) begin
          rdy_nxt = 1'b1;
        end
        if (baud_last) begin
          if (pend_vld_nxt) begin
            // Start the pending byte back-to-back, with no idle cycle.
            state_nxt    = S_START;
            tx_nxt       = 1'b0;
            shift_nxt    = pend_dat_nxt;
            bit_nxt      = 3'd0;
            pend_vld_nxt = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_nxt      = ^pend_dat_nxt;
`endif
          end else begin
            state_nxt = S_IDLE;
            tx_nxt    = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
        tx_nxt    = 1'b1;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE) || pend_vld_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= S_IDLE;
      baud_cnt                <= 16'd0;
      bit_cnt                 <= 3'd0;
      shift_q                 <= 8'd0;
      pend_vld                <= 1'b0;
      pend_dat                <= 8'd0;
      tx                      <= 1'b1;
      io_output_ready_trigger <= 1'b0;
      overrun                 <= 1'b0;
      busy                    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q                   <= 1'b0;
`endif
    end else begin
      state                   <= state_nxt;
      baud_cnt                <= baud_nxt;
      bit_cnt                 <= bit_nxt;
      shift_q                 <= shift_nxt;
      pend_vld                <= pend_vld_nxt;
      pend_dat                <= pend_dat_nxt;
      tx                      <= tx_nxt;
      io_output_ready_trigger <= rdy_nxt;
      overrun                 <= ovr_nxt;
      busy                    <= busy_nxt;
`ifdef UART_TX_PARITY_EN
      par_q                   <= par_nxt;
`endif
    end
  end

endmodule
